cam_exposure_ctrl: RTL and testbench



---
 rtl/cam_pkg.sv | 34 +++
 rtl/exp_sat_counter.sv | 39 +++
 rtl/cam_exposure_ctrl.sv | 144 ++++++++++++++
 tb/tb_cam_exposure_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants, state encoding and helpers for the camera exposure controller.
package cam_pkg;

  localparam int unsigned EXP_SIZE  = 5;
  localparam int unsigned EXP_MIN   = 2;
  localparam int unsigned EXP_MAX   = 30;
  localparam int unsigned EXP_RESET = 14;

  localparam int unsigned ADC_W     = 8;
  localparam int unsigned N_PIX     = 4;
  localparam int unsigned PIX_SHIFT = $clog2(N_PIX);
  localparam int unsigned SUM_W     = ADC_W + PIX_SHIFT;
  localparam int unsigned CNT_W     = PIX_SHIFT + 1;

  localparam int unsigned TARGET_LO = 96;
  localparam int unsigned TARGET_HI = 160;

  localparam int unsigned TIMEOUT   = 63;
  localparam int unsigned TIMER_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWait   = 2'b01,
    StAdjust = 2'b10
  } state_e;

  // N_PIX is a power of two, so the mean is a plain shift of the sum.
  function automatic logic [ADC_W-1:0] frame_avg(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] shifted;
    shifted = sum >> PIX_SHIFT;
    return shifted[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/exp_sat_counter.sv
// Exposure register: up/down by one with min/max saturation; inc and dec together hold.
module exp_sat_counter
  import cam_pkg::*;
#(
  parameter int unsigned Width    = EXP_SIZE,
  parameter int unsigned MinVal   = EXP_MIN,
  parameter int unsigned MaxVal   = EXP_MAX,
  parameter int unsigned ResetVal = EXP_RESET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] value
);

  logic [Width-1:0] value_q;
  logic [Width-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !dec && (value_q < Width'(MaxVal))) begin
      value_d = value_q + 1'b1;
    end else if (dec && !inc && (value_q > Width'(MinVal))) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= Width'(ResetVal);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/cam_exposure_ctrl.sv
// Frame scheduler and auto-exposure: launches a frame, averages N_PIX samples,
// nudges exposure toward the luminance window; manual buttons serviced while idle.
module cam_exposure_ctrl
  import cam_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                exp_incr,
  input  logic                exp_decr,
  input  logic                auto_en,
  input  logic                pix_valid,
  input  logic [ADC_W-1:0]    pix_data,
  input  logic                frame_done,
  output logic                cam_init,
  output logic [EXP_SIZE-1:0] exp_time,
  output logic                busy,
  output logic [ADC_W-1:0]    luma_avg,
  output logic                timeout_err
);

  state_e             state_q;
  logic [SUM_W-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic               done_q;
  logic               incr_prev_q;
  logic               decr_prev_q;
  logic               cam_init_q;
  logic               busy_q;
  logic [ADC_W-1:0]   luma_q;
  logic               timeout_q;

  logic [ADC_W-1:0]   avg_now;
  logic               exp_inc;
  logic               exp_dec;
  logic               frame_full;

  assign avg_now    = frame_avg(sum_q);
  assign frame_full = (cnt_q == CNT_W'(N_PIX));

  // Both the button path and the auto-adjust path steer the single exposure register.
  always_comb begin
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    case (state_q)
      StIdle: begin
        // A frame request swallows any button edge arriving on the same cycle.
        if (!init) begin
          exp_inc = exp_incr & ~incr_prev_q & ~exp_decr;
          exp_dec = exp_decr & ~decr_prev_q & ~exp_incr;
        end
      end
      StAdjust: begin
        if (auto_en) begin
          exp_inc = (avg_now < ADC_W'(TARGET_LO));
          exp_dec = (avg_now > ADC_W'(TARGET_HI));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      sum_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      done_q      <= 1'b0;
      incr_prev_q <= 1'b0;
      decr_prev_q <= 1'b0;
      cam_init_q  <= 1'b0;
      busy_q      <= 1'b0;
      luma_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // Edge history tracks the buttons in every state so a held press never fires late.
      incr_prev_q <= exp_incr;
      decr_prev_q <= exp_decr;
      cam_init_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (init) begin
            state_q    <= StWait;
            cam_init_q <= 1'b1;
            busy_q     <= 1'b1;
            sum_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        StWait: begin
          if (pix_valid && !frame_full) begin
            sum_q <= sum_q + SUM_W'(pix_data);
            cnt_q <= cnt_q + 1'b1;
          end
          if (frame_done) begin
            done_q <= 1'b1;
          end
          if (frame_full && done_q) begin
            state_q <= StAdjust;
          end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StAdjust: begin
          luma_q  <= avg_now;
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  exp_sat_counter #(
    .Width   (EXP_SIZE),
    .MinVal  (EXP_MIN),
    .MaxVal  (EXP_MAX),
    .ResetVal(EXP_RESET)
  ) u_exp_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (exp_inc),
    .dec  (exp_dec),
    .value(exp_time)
  );

  assign cam_init    = cam_init_q;
  assign busy        = busy_q;
  assign luma_avg    = luma_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cam_exposure_ctrl.sv
// Directed bench for cam_exposure_ctrl: a table of frames plus hand-written corner sequences.
module tb_cam_exposure_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       exp_incr;
  logic       exp_decr;
  logic       auto_en;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       frame_done;
  logic       cam_init;
  logic [4:0] exp_time;
  logic       busy;
  logic [7:0] luma_avg;
  logic       timeout_err;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic            auto_en;
    logic            early;
    logic            extra;
    logic [3:0][7:0] pix;
    logic [7:0]      luma;
    logic [4:0]      expt;
  } vec_t;

  vec_t tbl [7];

  cam_exposure_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .exp_incr   (exp_incr),
    .exp_decr   (exp_decr),
    .auto_en    (auto_en),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .cam_init   (cam_init),
    .exp_time   (exp_time),
    .busy       (busy),
    .luma_avg   (luma_avg),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic vec_t mk(input logic ae, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] l, input logic [4:0] e);
    vec_t v;
    v.auto_en = ae;
    v.early   = 1'b0;
    v.extra   = 1'b0;
    v.pix[0]  = a;
    v.pix[1]  = b;
    v.pix[2]  = c;
    v.pix[3]  = d;
    v.luma    = l;
    v.expt    = e;
    return v;
  endfunction

  task automatic press(input bit up, input int times);
    for (int i = 0; i < times; i++) begin
      if (up) exp_incr = 1'b1; else exp_decr = 1'b1;
      @(negedge clk);
      exp_incr = 1'b0;
      exp_decr = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int n;
    auto_en = v.auto_en;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk({tag, ".cam_init_hi"}, cam_init, 1);
    chk({tag, ".busy_hi"}, busy, 1);
    chk({tag, ".timeout_clr"}, timeout_err, 0);
    @(negedge clk);
    chk({tag, ".cam_init_lo"}, cam_init, 0);
    for (int i = 0; i < 4; i++) begin
      pix_valid  = 1'b1;
      pix_data   = v.pix[i];
      frame_done = v.early && (i == 2);
      @(negedge clk);
    end
    pix_valid  = 1'b0;
    frame_done = 1'b0;
    if (v.extra) begin
      pix_valid = 1'b1;
      pix_data  = 8'd255;
      @(negedge clk);
      pix_valid = 1'b0;
    end
    if (!v.early) begin
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
    end
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".busy_lo"}, busy, 0);
    chk({tag, ".luma"}, luma_avg, v.luma);
    chk({tag, ".exp"}, exp_time, v.expt);
  endtask

  initial begin
    vec_t v;
    int   n;

    // Chain of frames starting from exp_time=14.
    tbl[0] = mk(1'b1, 8'd40,  8'd50,  8'd60,  8'd70,  8'd55,  5'd15);
    tbl[1] = mk(1'b1, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 5'd14);
    tbl[2] = mk(1'b1, 8'd96,  8'd160, 8'd96,  8'd160, 8'd128, 5'd14);
    tbl[3] = mk(1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   5'd14);
    tbl[4] = mk(1'b1, 8'd95,  8'd96,  8'd96,  8'd96,  8'd95,  5'd15);
    tbl[5] = mk(1'b1, 8'd160, 8'd160, 8'd160, 8'd163, 8'd160, 5'd15);
    tbl[6] = mk(1'b1, 8'd161, 8'd161, 8'd161, 8'd161, 8'd161, 5'd14);

    reset = 1'b0; init = 1'b0; exp_incr = 1'b0; exp_decr = 1'b0;
    auto_en = 1'b0; pix_valid = 1'b0; pix_data = '0; frame_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.exp", exp_time, 14);
    chk("rst.busy", busy, 0);
    chk("rst.cam_init", cam_init, 0);
    chk("rst.luma", luma_avg, 0);
    chk("rst.timeout", timeout_err, 0);

    // Held button steps once.
    exp_incr = 1'b1;
    repeat (5) @(negedge clk);
    exp_incr = 1'b0;
    @(negedge clk);
    chk("btn.hold_incr", exp_time, 15);
    press(1'b0, 20);
    chk("btn.decr_sat", exp_time, 2);
    exp_incr = 1'b1; exp_decr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("btn.both", exp_time, 2);
    exp_incr = 1'b0; exp_decr = 1'b0;
    @(negedge clk);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2.exp", exp_time, 14);

    for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    // init beats a same-cycle button edge; the held button stays silent afterwards.
    exp_incr = 1'b1;
    run_frame(mk(1'b0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 5'd14), "prio");
    @(negedge clk);
    chk("prio.held", exp_time, 14);
    exp_incr = 1'b0;
    @(negedge clk);

    press(1'b1, 16);
    chk("sat.max_btn", exp_time, 30);
    v = mk(1'b1, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 5'd30);
    v.early = 1'b1;
    v.extra = 1'b1;
    run_frame(v, "sat_hi");
    press(1'b0, 28);
    chk("sat.min_btn", exp_time, 2);
    run_frame(mk(1'b1, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 5'd2), "sat_lo");

    // Frame that never delivers samples.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo.wait_cycles", n, 63);
    chk("tmo.flag", timeout_err, 1);
    chk("tmo.exp", exp_time, 2);
    chk("tmo.luma", luma_avg, 250);
    run_frame(mk(1'b0, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 5'd2), "tmo_next");
    chk("tmo_next.flag", timeout_err, 0);

    // Asynchronous reset in the middle of WAIT.
    auto_en = 1'b0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'd255;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.exp", exp_time, 14);
    chk("arst.luma", luma_avg, 0);
    chk("arst.cam_init", cam_init, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst.no_cam_init", cam_init, 0);
    chk("arst.idle", busy, 0);
    run_frame(mk(1'b0, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 5'd14), "arst_next");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
